bcd_alarm_ctrl: RTL and testbench
=================================

Name: bcd_alarm_ctrl

Overview:
- Downstream consumer of the 1 Hz BCD clock; takes its four time digits (HH:MM) on the same 1 Hz clk.
- Stores a user-set alarm time and raises a ring output when the running time reaches it.
- Supports snooze and stop.
- Sits between the clock core and the display/buzzer stage.

Parameters:
- RING_SECS, 60, number of clk cycles (seconds) alarm_ring stays high before auto-timeout.
- SNOOZE_SECS, 300, number of clk cycles of silence after a snooze before re-ringing.
- MAX_SNOOZE, 3, maximum snoozes per alarm event; further snooze presses are ignored.

Ports:
- clk  input  1  1 Hz system clock, shared with the clock core.
- rst  input  1  asynchronous, active-low reset.
- alarm_en  input  1  master enable; 0 forces IDLE.
- set_alarm  input  1  load alarm digits this cycle.
- set_ms_hr, set_ls_hr, set_ms_min, set_ls_min  input  4 each  BCD alarm time to load.
- time_ms_hr, time_ls_hr, time_ms_min, time_ls_min  input  4 each  BCD time from the clock core.
- snooze  input  1  snooze request (level sampled each clk).
- stop  input  1  dismiss request.
- alarm_ms_hr, alarm_ls_hr, alarm_ms_min, alarm_ls_min  output  4 each  stored alarm time readback.
- alarm_ring  output  1  ringing indicator.
- alarm_armed  output  1  high in any state except IDLE.
- snooze_count  output  $clog2(MAX_SNOOZE+1)  snoozes used in the current event.
- set_err  output  1  one-cycle pulse when set_alarm carries an invalid time.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; alarm digits 0,0,0,0; alarm_ring=0, alarm_armed=0, snooze_count=0, set_err=0; internal prev_match=0, all timers 0.
- Validity of a load: hours 00–23, minutes 00–59, and every digit ≤9.
  - Invalid load: stored digits unchanged; set_err=1 for the next cycle; state unchanged.
- match = (time digits == stored alarm digits), combinational; prev_match is match registered every cycle in all states.
- Trigger = match & ~prev_match & state==ARMED. Rising edge only, so a minute that already matches does not re-trigger after stop.
- Priority per cycle: rst > ~alarm_en > set_alarm > stop > snooze > timers/trigger.
- States and transitions:
  - IDLE: outputs quiet; alarm_en=1 -> ARMED. set_alarm loads digits in any state, including IDLE.
  - ARMED: trigger -> RINGING, with ring timer cleared and snooze_count=0.
  - RINGING: alarm_ring=1.
    - stop -> ARMED.
    - snooze with snooze_count<MAX_SNOOZE -> SNOOZE, snooze_count+1, snooze timer cleared.
    - snooze with snooze_count==MAX_SNOOZE is ignored.
    - Ring timer reaching RING_SECS-1 -> ARMED (timeout).
  - SNOOZE: alarm_ring=0. stop -> ARMED. Snooze timer reaching SNOOZE_SECS-1 -> RINGING with ring timer cleared.
  - Valid set_alarm in RINGING or SNOOZE: load digits, -> ARMED, snooze_count=0.
  - alarm_en=0 in any state -> IDLE next cycle; snooze_count cleared.
- Latency:
  - alarm_ring rises on the first clk edge at which time first equals the alarm. That is one cycle after the time inputs change, since the time inputs are registered upstream.
  - alarm_ring is high for exactly RING_SECS cycles if not dismissed.
- All outputs are registered. Timers saturate-free: each is cleared on state entry and sized $clog2(max(RING_SECS,SNOOZE_SECS)).
- Wrap-around: an alarm of 00:00 triggers on the 23:59 -> 00:00 transition.

Optional Feature:
- Macro ALARM_BEEP_EN.
  - Defined: extra output alarm_beep (1 bit). It toggles every cycle while in RINGING, starting at 1 on RINGING entry, and is 0 otherwise and at reset.
  - Undefined: the port is absent and there is no toggle logic.

Test Plan:
- Reset mid-RINGING (rst low) -> alarm_ring=0, state IDLE, alarm digits 0000 immediately (asynchronous).
- Load 07:30 with alarm_en=1; time steps 07:29 -> 07:30 -> alarm_ring=1 on the next edge, stays high 60 cycles, then 0 with alarm_armed=1; no re-ring during the rest of 07:30.
- Ringing at 07:30, snooze pulsed ->
  - alarm_ring=0 for 300 cycles, then 1 again with snooze_count=1.
  - Repeat snooze ×3; the 4th snooze is ignored and snooze_count stays 3.
- Load 24:00 or 12:65 -> set_err pulses one cycle, stored digits unchanged, state unchanged.
- Alarm 00:00, time 23:59 -> 00:00 -> rings. Assert stop plus snooze in the same cycle -> stop wins, ARMED.
- alarm_en dropped during SNOOZE -> IDLE next cycle; no ring when the snooze would have expired; snooze_count=0.

Source files
------------

// File: rtl/bcd_alarm_ctrl.sv
// bcd_alarm_ctrl: alarm compare/ring/snooze FSM fed by the 1 Hz BCD clock.
// Ports: clk, rst(async low), alarm_en, set_alarm+set_* digits, time_* digits,
//   snooze, stop -> alarm_* readback, alarm_ring, alarm_armed, snooze_count,
//   set_err; alarm_beep only when ALARM_BEEP_EN is defined.
module bcd_alarm_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarm_en,
  input  logic       set_alarm,
  input  logic [3:0] set_ms_hr,
  input  logic [3:0] set_ls_hr,
  input  logic [3:0] set_ms_min,
  input  logic [3:0] set_ls_min,
  input  logic [3:0] time_ms_hr,
  input  logic [3:0] time_ls_hr,
  input  logic [3:0] time_ms_min,
  input  logic [3:0] time_ls_min,
  input  logic       snooze,
  input  logic       stop,
  output logic [3:0] alarm_ms_hr,
  output logic [3:0] alarm_ls_hr,
  output logic [3:0] alarm_ms_min,
  output logic [3:0] alarm_ls_min,
  output logic       alarm_ring,
  output logic       alarm_armed,
  output logic [$clog2(MAX_SNOOZE+1)-1:0] snooze_count,
`ifdef ALARM_BEEP_EN
  output logic       alarm_beep,
`endif
  output logic       set_err
);

  localparam int TMAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int CW   = $clog2(MAX_SNOOZE+1);

  typedef enum logic [1:0] {
    IDLE, ARMED, RINGING, SNOOZE
  } state_t;

  state_t          state, nxt;
  logic            prev_match;
  logic [TW-1:0]   ring_tmr, snz_tmr;
  logic            valid, hr_ok, min_ok, match, trigger, load;
  logic            ring_clr, ring_run, snz_clr, snz_run;
  logic            cnt_clr, cnt_inc;

  assign hr_ok  = (set_ms_hr < 4'd2 && set_ls_hr <= 4'd9)
               || (set_ms_hr == 4'd2 && set_ls_hr <= 4'd3);
  assign min_ok = set_ms_min <= 4'd5 && set_ls_min <= 4'd9;
  assign valid  = hr_ok && min_ok;
  assign load   = set_alarm && valid;

  assign match = {time_ms_hr, time_ls_hr, time_ms_min, time_ls_min}
              == {alarm_ms_hr, alarm_ls_hr, alarm_ms_min, alarm_ls_min};
  // Edge-only trigger: a minute that still matches after stop won't re-ring.
  assign trigger = match && !prev_match && state == ARMED;

  always_comb begin
    nxt      = state;
    ring_clr = 1'b0;
    ring_run = 1'b0;
    snz_clr  = 1'b0;
    snz_run  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    if (!alarm_en) begin
      nxt     = IDLE;
      cnt_clr = 1'b1;
    end else if (set_alarm) begin
      // An invalid load leaves the state untouched.
      if (valid) begin
        if (state == RINGING || state == SNOOZE) begin
          nxt     = ARMED;
          cnt_clr = 1'b1;
        end else begin
          nxt = ARMED;
        end
      end
    end else begin
      case (state)
        IDLE: nxt = ARMED;
        ARMED: begin
          if (trigger) begin
            nxt      = RINGING;
            ring_clr = 1'b1;
            cnt_clr  = 1'b1;
          end
        end
        RINGING: begin
          if (stop) begin
            nxt = ARMED;
          end else if (snooze && snooze_count < CW'(MAX_SNOOZE)) begin
            nxt     = SNOOZE;
            snz_clr = 1'b1;
            cnt_inc = 1'b1;
          end else if (ring_tmr == TW'(RING_SECS-1)) begin
            nxt = ARMED;
          end else begin
            ring_run = 1'b1;
          end
        end
        SNOOZE: begin
          if (stop) begin
            nxt = ARMED;
          end else if (snz_tmr == TW'(SNOOZE_SECS-1)) begin
            nxt      = RINGING;
            ring_clr = 1'b1;
          end else begin
            snz_run = 1'b1;
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      prev_match   <= 1'b0;
      alarm_ms_hr  <= '0;
      alarm_ls_hr  <= '0;
      alarm_ms_min <= '0;
      alarm_ls_min <= '0;
      alarm_ring   <= 1'b0;
      alarm_armed  <= 1'b0;
      snooze_count <= '0;
      set_err      <= 1'b0;
      ring_tmr     <= '0;
      snz_tmr      <= '0;
`ifdef ALARM_BEEP_EN
      alarm_beep   <= 1'b0;
`endif
    end else begin
      state       <= nxt;
      prev_match  <= match;
      set_err     <= set_alarm && !valid;
      alarm_ring  <= (nxt == RINGING);
      alarm_armed <= (nxt != IDLE);
      if (load) begin
        alarm_ms_hr  <= set_ms_hr;
        alarm_ls_hr  <= set_ls_hr;
        alarm_ms_min <= set_ms_min;
        alarm_ls_min <= set_ls_min;
      end
      if (cnt_clr)
        snooze_count <= '0;
      else if (cnt_inc)
        snooze_count <= snooze_count + CW'(1);
      if (ring_clr)
        ring_tmr <= '0;
      else if (ring_run)
        ring_tmr <= ring_tmr + TW'(1);
      if (snz_clr)
        snz_tmr <= '0;
      else if (snz_run)
        snz_tmr <= snz_tmr + TW'(1);
`ifdef ALARM_BEEP_EN
      if (nxt != RINGING)
        alarm_beep <= 1'b0;
      else if (state != RINGING)
        alarm_beep <= 1'b1;
      else
        alarm_beep <= !alarm_beep;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_alarm_ctrl.sv
// tb_bcd_alarm_ctrl: directed bench for bcd_alarm_ctrl.
// Drives time/alarm vectors and checks ring, snooze and load behaviour.
module tb_bcd_alarm_ctrl;

  logic       clk;
  logic       rst;
  logic       alarm_en;
  logic       set_alarm;
  logic [3:0] set_ms_hr, set_ls_hr, set_ms_min, set_ls_min;
  logic [3:0] time_ms_hr, time_ls_hr, time_ms_min, time_ls_min;
  logic       snooze;
  logic       stop;
  logic [3:0] alarm_ms_hr, alarm_ls_hr, alarm_ms_min, alarm_ls_min;
  logic       alarm_ring;
  logic       alarm_armed;
  logic [1:0] snooze_count;
  logic       set_err;
`ifdef ALARM_BEEP_EN
  logic       alarm_beep;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] alarm_v;
  assign alarm_v = {alarm_ms_hr, alarm_ls_hr, alarm_ms_min, alarm_ls_min};

  bcd_alarm_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .alarm_en     (alarm_en),
    .set_alarm    (set_alarm),
    .set_ms_hr    (set_ms_hr),
    .set_ls_hr    (set_ls_hr),
    .set_ms_min   (set_ms_min),
    .set_ls_min   (set_ls_min),
    .time_ms_hr   (time_ms_hr),
    .time_ls_hr   (time_ls_hr),
    .time_ms_min  (time_ms_min),
    .time_ls_min  (time_ls_min),
    .snooze       (snooze),
    .stop         (stop),
    .alarm_ms_hr  (alarm_ms_hr),
    .alarm_ls_hr  (alarm_ls_hr),
    .alarm_ms_min (alarm_ms_min),
    .alarm_ls_min (alarm_ls_min),
    .alarm_ring   (alarm_ring),
    .alarm_armed  (alarm_armed),
    .snooze_count (snooze_count),
`ifdef ALARM_BEEP_EN
    .alarm_beep   (alarm_beep),
`endif
    .set_err      (set_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
    time_ms_hr  = a;
    time_ls_hr  = b;
    time_ms_min = c;
    time_ls_min = d;
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    set_ms_hr  = a;
    set_ls_hr  = b;
    set_ms_min = c;
    set_ls_min = d;
    set_alarm  = 1'b1;
    tick;
    set_alarm  = 1'b0;
  endtask

  task automatic pulse_snooze;
    snooze = 1'b1;
    tick;
    snooze = 1'b0;
  endtask

  task automatic pulse_stop;
    stop = 1'b1;
    tick;
    stop = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    rst       = 1'b0;
    alarm_en  = 1'b0;
    set_alarm = 1'b0;
    snooze    = 1'b0;
    stop      = 1'b0;
    set_ms_hr = '0; set_ls_hr = '0; set_ms_min = '0; set_ls_min = '0;
    set_time(4'd1, 4'd2, 4'd0, 4'd0);
    #2;
    chk("rst_ring", 32'(alarm_ring), 0);
    chk("rst_armed", 32'(alarm_armed), 0);
    chk("rst_cnt", 32'(snooze_count), 0);
    chk("rst_err", 32'(set_err), 0);
    chk("rst_digits", 32'(alarm_v), 0);
    tick;
    tick;
    rst = 1'b1;
    tick;
    chk("idle_en0", 32'(alarm_armed), 0);

    // Basic ring at 07:30 with full timeout.
    alarm_en = 1'b1;
    load(4'd0, 4'd7, 4'd3, 4'd0);
    chk("load_digits", 32'(alarm_v), 32'h0730);
    chk("load_armed", 32'(alarm_armed), 1);
    chk("load_err", 32'(set_err), 0);
    set_time(4'd0, 4'd7, 4'd2, 4'd9);
    tick;
    chk("pre_ring", 32'(alarm_ring), 0);
    set_time(4'd0, 4'd7, 4'd3, 4'd0);
    tick;
    chk("trigger", 32'(alarm_ring), 1);
    n = 0;
    while (alarm_ring && n < 200) begin
      n++;
      tick;
    end
    chk("ring_len", 32'(n), 60);
    chk("timeout_armed", 32'(alarm_armed), 1);
    seen = 1'b0;
    repeat (20) begin
      tick;
      if (alarm_ring) seen = 1'b1;
    end
    chk("no_rering", 32'(seen), 0);

    // Snooze three times, fourth ignored.
    set_time(4'd0, 4'd7, 4'd3, 4'd1);
    tick;
    set_time(4'd0, 4'd7, 4'd3, 4'd0);
    tick;
    chk("retrigger", 32'(alarm_ring), 1);
    for (int k = 1; k <= 3; k++) begin
      pulse_snooze;
      chk("snz_quiet", 32'(alarm_ring), 0);
      chk("snz_cnt", 32'(snooze_count), 32'(k));
      n = 0;
      while (!alarm_ring && n < 1000) begin
        n++;
        tick;
      end
      chk("snz_len", 32'(n), 300);
      chk("snz_rering", 32'(alarm_ring), 1);
    end
    pulse_snooze;
    chk("snz_ignored", 32'(alarm_ring), 1);
    chk("snz_max", 32'(snooze_count), 3);
    pulse_stop;
    chk("stop_ring", 32'(alarm_ring), 0);
    chk("stop_armed", 32'(alarm_armed), 1);

    // Invalid loads.
    load(4'd2, 4'd4, 4'd0, 4'd0);
    chk("err_2400", 32'(set_err), 1);
    chk("keep_2400", 32'(alarm_v), 32'h0730);
    chk("armed_2400", 32'(alarm_armed), 1);
    tick;
    chk("err_clear", 32'(set_err), 0);
    load(4'd1, 4'd2, 4'd6, 4'd5);
    chk("err_1265", 32'(set_err), 1);
    chk("keep_1265", 32'(alarm_v), 32'h0730);
    tick;

    // Midnight wrap, stop beats snooze.
    load(4'd0, 4'd0, 4'd0, 4'd0);
    chk("load_0000", 32'(alarm_v), 0);
    chk("load_0000_err", 32'(set_err), 0);
    set_time(4'd2, 4'd3, 4'd5, 4'd9);
    tick;
    set_time(4'd0, 4'd0, 4'd0, 4'd0);
    tick;
    chk("wrap_ring", 32'(alarm_ring), 1);
    chk("wrap_cnt", 32'(snooze_count), 0);
    stop = 1'b1;
    snooze = 1'b1;
    tick;
    stop = 1'b0;
    snooze = 1'b0;
    chk("stopwin_ring", 32'(alarm_ring), 0);
    chk("stopwin_armed", 32'(alarm_armed), 1);
    chk("stopwin_cnt", 32'(snooze_count), 0);

    // Enable dropped during snooze.
    set_time(4'd2, 4'd3, 4'd5, 4'd9);
    tick;
    set_time(4'd0, 4'd0, 4'd0, 4'd0);
    tick;
    chk("en_ring", 32'(alarm_ring), 1);
    pulse_snooze;
    chk("en_snz_cnt", 32'(snooze_count), 1);
    repeat (10) tick;
    alarm_en = 1'b0;
    tick;
    chk("en_idle", 32'(alarm_armed), 0);
    chk("en_cnt", 32'(snooze_count), 0);
    chk("en_quiet", 32'(alarm_ring), 0);
    seen = 1'b0;
    repeat (320) begin
      tick;
      if (alarm_ring) seen = 1'b1;
    end
    chk("en_no_ring", 32'(seen), 0);

    // Asynchronous reset while ringing.
    alarm_en = 1'b1;
    load(4'd0, 4'd7, 4'd3, 4'd0);
    chk("rearm", 32'(alarm_armed), 1);
    set_time(4'd0, 4'd7, 4'd2, 4'd9);
    tick;
    set_time(4'd0, 4'd7, 4'd3, 4'd0);
    tick;
    chk("pre_rst_ring", 32'(alarm_ring), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_ring", 32'(alarm_ring), 0);
    chk("arst_armed", 32'(alarm_armed), 0);
    chk("arst_digits", 32'(alarm_v), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
